// File: rtl/dma_write_sequencer.sv
// DMA write sequencer: turns the software run bit and the FIFO fill level into fixed-length
// write commands over a circular DDR buffer, with progress status and a sticky interrupt.
module dma_write_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BURST_BYTES = 1024,
  parameter int unsigned BUF_BYTES   = 65536
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [31:0]       DMA_TRIGGER,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [CNT_W-1:0]  FIFO_COUNT,
  output logic              CMD_VALID,
  input  logic              CMD_READY,
  output logic [ADDR_W-1:0] CMD_ADDR,
  output logic [7:0]        CMD_LEN,
  input  logic              WR_DONE,
  input  logic              WR_ERR,
  output logic              IRQ,
  output logic [31:0]       DMA_STATUS,
  output logic [ADDR_W-1:0] WR_PTR
);

  localparam int unsigned BEATS = BURST_BYTES / 4;
  localparam int unsigned OFF_W = $clog2(BUF_BYTES);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitData = 3'd1,
    StIssue    = 3'd2,
    StWaitDone = 3'd3,
    StError    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [OFF_W-1:0]  offset_q, offset_d, offset_inc;
  logic [15:0]       burst_cnt_q, burst_cnt_d;
  logic              wrapped_q, wrapped_d;
  logic              half_q, half_d;
  logic              error_q, error_d;
  logic              irq_q, irq_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              clr_q;
  logic              run, irq_set, irq_clr;
  logic              unused_trigger;

  assign run            = DMA_TRIGGER[0];
  assign irq_clr        = DMA_TRIGGER[1] & ~clr_q;
  assign unused_trigger = ^DMA_TRIGGER[31:2];
  // Offset width equals log2 of the ring size, so the carry-out is the modulo.
  assign offset_inc     = offset_q + OFF_W'(BURST_BYTES);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cmd_addr_d  = cmd_addr_q;
    offset_d    = offset_q;
    burst_cnt_d = burst_cnt_q;
    wrapped_d   = wrapped_q;
    half_d      = half_q;
    error_d     = error_q;
    cmd_valid_d = cmd_valid_q;
    irq_set     = 1'b0;
    case (state_q)
      StIdle: begin
        if (run) begin
          base_d    = BASE_ADDR;
          offset_d  = '0;
          wrapped_d = 1'b0;
          state_d   = StWaitData;
        end
      end
      StWaitData: begin
        if (!run) begin
          state_d = StIdle;
        end else if (FIFO_COUNT >= CNT_W'(BEATS)) begin
          cmd_valid_d = 1'b1;
          cmd_addr_d  = base_q + ADDR_W'(offset_q);
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (CMD_READY) begin
          cmd_valid_d = 1'b0;
          state_d     = StWaitDone;
        end
      end
      StWaitDone: begin
        if (WR_DONE) begin
          if (WR_ERR) begin
            error_d = 1'b1;
            irq_set = 1'b1;
            state_d = StError;
          end else begin
            offset_d    = offset_inc;
            burst_cnt_d = burst_cnt_q + 16'd1;
            if (offset_inc == OFF_W'(BUF_BYTES / 2)) begin
              irq_set = 1'b1;
              half_d  = 1'b1;
            end
            if (offset_inc == '0) begin
              irq_set   = 1'b1;
              wrapped_d = 1'b1;
              half_d    = 1'b0;
            end
            state_d = StWaitData;
          end
        end
      end
      StError: begin
        if (!run) begin
          error_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A set in the same cycle as a clear wins.
    irq_d = irq_set | (irq_q & ~irq_clr);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= StIdle;
      base_q      <= '0;
      cmd_addr_q  <= '0;
      offset_q    <= '0;
      burst_cnt_q <= '0;
      wrapped_q   <= 1'b0;
      half_q      <= 1'b0;
      error_q     <= 1'b0;
      irq_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cmd_addr_q  <= cmd_addr_d;
      offset_q    <= offset_d;
      burst_cnt_q <= burst_cnt_d;
      wrapped_q   <= wrapped_d;
      half_q      <= half_d;
      error_q     <= error_d;
      irq_q       <= irq_d;
      cmd_valid_q <= cmd_valid_d;
      clr_q       <= DMA_TRIGGER[1];
    end
  end

  assign CMD_VALID  = cmd_valid_q;
  assign CMD_ADDR   = cmd_addr_q;
  assign CMD_LEN    = 8'(BEATS - 1);
  assign IRQ        = irq_q;
  assign WR_PTR     = ADDR_W'(offset_q);
  assign DMA_STATUS = {burst_cnt_q, 9'd0, half_q, wrapped_q, error_q, 1'b0, state_q};

endmodule

// File: tb/tb_dma_write_sequencer.sv
// Bench for dma_write_sequencer: directed scenarios plus a randomized run, all checked every
// cycle against a behavioural model of the sequencer built from its rules.
module tb_dma_write_sequencer;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned BURST_BYTES = 1024;
  localparam int unsigned BUF_BYTES   = 4096;
  localparam int unsigned BEATS       = BURST_BYTES / 4;

  logic              S_AXI_ACLK    = 1'b0;
  logic              S_AXI_ARESETN = 1'b0;
  logic [31:0]       DMA_TRIGGER   = '0;
  logic [ADDR_W-1:0] BASE_ADDR     = '0;
  logic [CNT_W-1:0]  FIFO_COUNT    = '0;
  logic              CMD_READY     = 1'b0;
  logic              WR_DONE       = 1'b0;
  logic              WR_ERR        = 1'b0;
  logic              CMD_VALID;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [7:0]        CMD_LEN;
  logic              IRQ;
  logic [31:0]       DMA_STATUS;
  logic [ADDR_W-1:0] WR_PTR;

  dma_write_sequencer #(
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W),
    .BURST_BYTES(BURST_BYTES),
    .BUF_BYTES  (BUF_BYTES)
  ) dut (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .S_AXI_ARESETN(S_AXI_ARESETN),
    .DMA_TRIGGER  (DMA_TRIGGER),
    .BASE_ADDR    (BASE_ADDR),
    .FIFO_COUNT   (FIFO_COUNT),
    .CMD_VALID    (CMD_VALID),
    .CMD_READY    (CMD_READY),
    .CMD_ADDR     (CMD_ADDR),
    .CMD_LEN      (CMD_LEN),
    .WR_DONE      (WR_DONE),
    .WR_ERR       (WR_ERR),
    .IRQ          (IRQ),
    .DMA_STATUS   (DMA_STATUS),
    .WR_PTR       (WR_PTR)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode numbers are the state codes software reads in DMA_STATUS.
  int          m_mode  = 0;
  logic [31:0] m_base  = '0;
  int unsigned m_off   = 0;
  int unsigned m_cnt   = 0;
  bit          m_wrap  = 0;
  bit          m_half  = 0;
  bit          m_err   = 0;
  bit          m_irq   = 0;
  bit          m_prevc = 0;
  bit          m_valid = 0;
  logic [31:0] m_addr  = '0;
  bit          m_run, m_clr, m_set;

  always @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      m_mode = 0; m_base = '0; m_off = 0; m_cnt = 0; m_wrap = 0; m_half = 0;
      m_err = 0; m_irq = 0; m_prevc = 0; m_valid = 0; m_addr = '0;
    end else begin
      m_run   = DMA_TRIGGER[0];
      m_clr   = DMA_TRIGGER[1] && !m_prevc;
      m_prevc = DMA_TRIGGER[1];
      m_set   = 0;
      if (m_mode == 0) begin
        if (m_run) begin
          m_base = BASE_ADDR; m_off = 0; m_wrap = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (!m_run) m_mode = 0;
        else if (int'(FIFO_COUNT) >= int'(BEATS)) begin
          m_mode = 2; m_valid = 1; m_addr = m_base + m_off;
        end
      end else if (m_mode == 2) begin
        if (CMD_READY) begin
          m_mode = 3; m_valid = 0;
        end
      end else if (m_mode == 3) begin
        if (WR_DONE && WR_ERR) begin
          m_err = 1; m_set = 1; m_mode = 4;
        end else if (WR_DONE) begin
          m_off = (m_off + BURST_BYTES) % BUF_BYTES;
          m_cnt = (m_cnt + 1) % 65536;
          if (m_off == BUF_BYTES / 2) begin m_set = 1; m_half = 1; end
          if (m_off == 0) begin m_set = 1; m_wrap = 1; m_half = 0; end
          m_mode = 1;
        end
      end else begin
        if (!m_run) begin m_err = 0; m_mode = 0; end
      end
      if (m_set) m_irq = 1;
      else if (m_clr) m_irq = 0;
    end
  end

  always @(negedge S_AXI_ACLK) begin
    check("cycle CMD_VALID", CMD_VALID, m_valid);
    check("cycle CMD_ADDR", CMD_ADDR, m_addr);
    check("cycle CMD_LEN", CMD_LEN, BEATS - 1);
    check("cycle IRQ", IRQ, m_irq);
    check("cycle DMA_STATUS", DMA_STATUS,
          {16'(m_cnt), 9'd0, m_half, m_wrap, m_err, 1'b0, 3'(m_mode)});
    check("cycle WR_PTR", WR_PTR, m_off);
  end

  // Stimulus: one driver process; the write engine responds a set delay after each handshake.
  int          pend       = -1;
  int          resp_delay = 0;
  bit          force_err  = 0;
  int unsigned err_rate   = 0;
  bit          rand_mode  = 0;

  task automatic step();
    bit hs;
    hs = (CMD_VALID === 1'b1) && (CMD_READY === 1'b1) && S_AXI_ARESETN;
    @(negedge S_AXI_ACLK);
    WR_DONE = 1'b0;
    WR_ERR  = 1'b0;
    if (hs) pend = (resp_delay >= 0) ? resp_delay : int'($urandom_range(0, 4));
    if (pend == 0) begin
      WR_DONE = 1'b1;
      WR_ERR  = force_err || (err_rate != 0 && $urandom_range(0, err_rate - 1) == 0);
      pend    = -1;
    end else if (pend > 0) begin
      pend--;
    end
    if (rand_mode) begin
      CMD_READY  = ($urandom_range(0, 2) == 0);
      FIFO_COUNT = CNT_W'($urandom_range(BEATS - 8, BEATS + 8));
      BASE_ADDR  = $urandom & 32'hFFFF_F000;
      if ($urandom_range(0, 59) == 0) DMA_TRIGGER[0] = ~DMA_TRIGGER[0];
      if ($urandom_range(0, 9) == 0) DMA_TRIGGER[1] = ~DMA_TRIGGER[1];
      if ($urandom_range(0, 19) == 0) DMA_TRIGGER[31:2] = 30'($urandom);
      if (pend < 0 && !WR_DONE && $urandom_range(0, 39) == 0) begin
        WR_DONE = 1'b1;
        WR_ERR  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic do_burst(input logic [31:0] exp_addr, input string tag);
    int n;
    n = 0;
    while (CMD_VALID !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check({tag, " valid"}, CMD_VALID, 1'b1);
    check({tag, " addr"}, CMD_ADDR, exp_addr);
    CMD_READY = 1'b1;
    step();
    CMD_READY = 1'b0;
    step();
  endtask

  initial begin
    repeat (2) @(negedge S_AXI_ACLK);
    check("reset CMD_VALID", CMD_VALID, 1'b0);
    check("reset CMD_ADDR", CMD_ADDR, 32'h0);
    check("reset CMD_LEN", CMD_LEN, 8'hFF);
    check("reset IRQ", IRQ, 1'b0);
    check("reset DMA_STATUS", DMA_STATUS, 32'h0);
    check("reset WR_PTR", WR_PTR, 32'h0);
    S_AXI_ARESETN = 1'b1;

    // Basic burst
    BASE_ADDR   = 32'h1000_0000;
    FIFO_COUNT  = 16'd256;
    DMA_TRIGGER = 32'h1;
    step();
    check("basic valid after 1", CMD_VALID, 1'b0);
    step();
    check("basic valid after 2", CMD_VALID, 1'b1);
    check("basic addr", CMD_ADDR, 32'h1000_0000);
    check("basic len", CMD_LEN, 8'hFF);
    CMD_READY = 1'b1;
    step();
    CMD_READY  = 1'b0;
    FIFO_COUNT = 16'd255;
    step();
    check("basic WR_PTR", WR_PTR, 32'h400);
    check("basic burst_count", DMA_STATUS[31:16], 16'd1);

    // Threshold
    for (int i = 0; i < 20; i++) begin
      step();
      check("threshold no valid", CMD_VALID, 1'b0);
    end
    FIFO_COUNT = 16'd256;
    step();
    check("threshold valid", CMD_VALID, 1'b1);
    check("threshold addr", CMD_ADDR, 32'h1000_0400);

    // Ring wrap over a 4-burst ring
    do_burst(32'h1000_0400, "b2");
    check("half WR_PTR", WR_PTR, 32'h800);
    check("half IRQ", IRQ, 1'b1);
    check("half flag", DMA_STATUS[6], 1'b1);
    DMA_TRIGGER = 32'h3;
    step();
    check("irq clear", IRQ, 1'b0);
    DMA_TRIGGER = 32'h1;
    do_burst(32'h1000_0800, "b3");
    do_burst(32'h1000_0C00, "b4");
    check("wrap WR_PTR", WR_PTR, 32'h0);
    check("wrap flag", DMA_STATUS[5], 1'b1);
    check("wrap half cleared", DMA_STATUS[6], 1'b0);
    check("wrap IRQ", IRQ, 1'b1);
    check("wrap count", DMA_STATUS[31:16], 16'd4);
    step();
    check("post-wrap valid", CMD_VALID, 1'b1);
    check("post-wrap addr", CMD_ADDR, 32'h1000_0000);

    // Backpressure with run dropped mid-wait
    for (int i = 0; i < 10; i++) begin
      if (i == 2) DMA_TRIGGER = 32'h0;
      step();
      check("bp valid held", CMD_VALID, 1'b1);
      check("bp addr held", CMD_ADDR, 32'h1000_0000);
    end
    CMD_READY = 1'b1;
    step();
    CMD_READY = 1'b0;
    step();
    check("bp back to wait_data", DMA_STATUS[2:0], 3'd1);
    step();
    check("bp idle", DMA_STATUS[2:0], 3'd0);

    // Error response
    DMA_TRIGGER = 32'h3;
    step();
    check("err pre IRQ", IRQ, 1'b0);
    do_burst(32'h1000_0000, "e1");
    force_err = 1'b1;
    do_burst(32'h1000_0400, "e2");
    force_err = 1'b0;
    check("err state", DMA_STATUS[2:0], 3'd4);
    check("err flag", DMA_STATUS[4], 1'b1);
    check("err IRQ", IRQ, 1'b1);
    check("err WR_PTR", WR_PTR, 32'h400);
    DMA_TRIGGER = 32'h0;
    step();
    check("err exit state", DMA_STATUS[2:0], 3'd0);
    check("err exit flag", DMA_STATUS[4], 1'b0);

    // Asynchronous reset while a response is outstanding
    DMA_TRIGGER = 32'h1;
    do_burst(32'h1000_0000, "r1");
    resp_delay = 1000;
    do_burst(32'h1000_0400, "r2");
    step();
    check("rst pre state", DMA_STATUS[2:0], 3'd3);
    #2;
    S_AXI_ARESETN = 1'b0;
    #1;
    check("async CMD_VALID", CMD_VALID, 1'b0);
    check("async CMD_ADDR", CMD_ADDR, 32'h0);
    check("async IRQ", IRQ, 1'b0);
    check("async DMA_STATUS", DMA_STATUS, 32'h0);
    check("async WR_PTR", WR_PTR, 32'h0);
    DMA_TRIGGER = 32'h0;
    resp_delay  = 0;
    pend        = -1;
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    pend = 0;
    step();
    step();
    check("late done status", DMA_STATUS, 32'h0);
    check("late done WR_PTR", WR_PTR, 32'h0);

    // Randomized run against the model
    resp_delay  = -1;
    err_rate    = 8;
    rand_mode   = 1'b1;
    DMA_TRIGGER = 32'h1;
    repeat (4000) step();
    rand_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
